// File: rtl/sigdelay_ctrl.sv
// Sequencing controller for the microphone delay line.
// Drives the RAM write/read enables and the applied offset. It counts the samples
// written since the last start or retune, and holds `valid` low until the buffer
// holds `offset` fresh samples plus the RAM read latency.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | stopped; wr/rd/valid low; waits for en
// FILL  | writing; counts offset fresh samples before reads may start
// RUN   | writing and reading; valid follows rd after RD_LATENCY cycles
module sigdelay_ctrl #(
  parameter int A_WIDTH        = 9,
  parameter int RD_LATENCY     = 1,
  parameter int DEFAULT_OFFSET = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [A_WIDTH-1:0] offset_req,
  input  logic               offset_load,
  output logic               wr,
  output logic               rd,
  output logic [A_WIDTH-1:0] offset,
  output logic               valid,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [A_WIDTH-1:0] ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};

  state_t             state_q;
  state_t             state_d;
  logic [A_WIDTH-1:0] fill_cnt;
  logic [A_WIDTH-1:0] offset_clamped;
  logic [RD_LATENCY:0] vpipe;
  logic               fill_done;
  logic               restart;
  logic               wr_d;
  logic               rd_d;

  // An offset of zero would make the write and read addresses collide, so it is
  // forced to the shortest usable delay.
  assign offset_clamped = (offset_req == '0) ? ONE : offset_req;

  // fill_cnt tracks the current (possibly just retuned) offset, so a completed
  // fill always means `offset` fresh samples are in the buffer.
  assign fill_done = (fill_cnt == offset - ONE);

  // Stage 0 of the pipe mirrors rd; the last stage is the delayed valid flag.
  assign valid = vpipe[RD_LATENCY];
  assign state = state_q;

  // Next-state logic: disable beats retune, and retune beats fill completion.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILL;
          restart = 1'b1;
        end
        FILL: begin
          if (offset_load) begin
            restart = 1'b1;
          end else if (fill_done) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (offset_load) begin
            state_d = FILL;
            restart = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    wr_d = (state_d != IDLE);
    rd_d = (state_d == RUN);
  end

  // State register and registered RAM enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr      <= 1'b0;
      rd      <= 1'b0;
    end else begin
      state_q <= state_d;
      wr      <= wr_d;
      rd      <= rd_d;
    end
  end

  // Offset latch: loads in any state, including alongside a disable.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= A_WIDTH'(DEFAULT_OFFSET);
    end else if (offset_load) begin
      offset <= offset_clamped;
    end
  end

  // Fill counter: cleared on each entry to FILL and advanced only while staying
  // in FILL, so it stops at offset-1 and cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (restart) begin
      fill_cnt <= '0;
    end else if (state_q == FILL && state_d == FILL) begin
      fill_cnt <= fill_cnt + ONE;
    end
  end

  // Valid pipe: flushed whenever reads stop, so a retune or disable never lets a
  // stale read through.
  always_ff @(posedge clk) begin
    if (rst || !rd_d) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= 1'b1;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

endmodule

// File: doc/sigdelay_ctrl.md
# sigdelay_ctrl

Sequencing controller for the microphone delay line (counter + dual-port RAM, write address = read address + offset). It drives the RAM write/read enables and the programmed offset, and tracks how many samples have been written since the last start or retune. It holds the delayed output invalid until the buffer contains `offset` fresh samples, so stale RAM contents never reach the output. It sits between the top-level control (enable, offset request) and the delay datapath, one clock domain.

## Interface
- `A_WIDTH`, 9: address width of the delay RAM; offset and fill-counter width.
- `RD_LATENCY`, 1: cycles from `rd` high to valid data on the RAM output; range 0..3.
- `DEFAULT_OFFSET`, 64: offset value after reset; must be 1..2^A_WIDTH-1.

- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request; level-sensitive.
- `offset_req`  in  A_WIDTH  requested delay in cycles.
- `offset_load`  in  1  one-cycle strobe; latch `offset_req`.
- `wr`  out  1  RAM write enable.
- `rd`  out  1  RAM read enable.
- `offset`  out  A_WIDTH  offset applied to the datapath.
- `valid`  out  1  high when the delayed output carries a correctly delayed sample.
- `state`  out  2  0 = IDLE, 1 = FILL, 2 = RUN. Encoding 3 is never produced.

## Operation
- All outputs are registered.
- Fill counter `fill_cnt` is A_WIDTH bits wide. It is cleared on every entry to FILL and increments on each cycle in FILL.
- Offset latch:
  - Strobing `offset_load` loads `offset_req` into `offset` on the next edge, in any state.
  - `offset_req` = 0 is clamped to 1.
  - `offset` is otherwise held.
- IDLE: `wr`=0, `rd`=0, `valid`=0. If `en`=1, go to FILL.
- FILL:
  - `wr`=1, `rd`=0, `valid`=0.
  - When `fill_cnt` == `offset`-1, go to RUN.
- RUN:
  - `wr`=1, `rd`=1.
  - `valid` rises RD_LATENCY cycles after the first `rd`, via a shift pipe of `rd`.
- Retune: `offset_load` in FILL or RUN goes to FILL with the new offset. This drops `rd`, clears the `valid` pipe and restarts `fill_cnt`. `wr` stays 1 throughout.
- Disable: `en`=0 in any state goes to IDLE on the next edge and clears the `valid` pipe.
- Simultaneous `en`=0 and `offset_load`: the offset is latched and the block goes to IDLE. Disable has priority over retune.
- Simultaneous `offset_load` and FILL completion: retune wins; the block stays in FILL with `fill_cnt` cleared.
- Wrap-around: `fill_cnt` never exceeds `offset`-1, so it never overflows. Datapath address wrap needs no handling here.

## Timing
- Reset values: `state`=IDLE, `wr`=0, `rd`=0, `valid`=0, `offset`=DEFAULT_OFFSET, `fill_cnt`=0, `valid` pipe all 0.
- Reset mid-operation has the same effect as power-on reset, on the next edge.
- Start, with `en` rising while sampled at edge 0:
  - `wr`=1 from cycle 1.
  - `rd`=1 from cycle 1+`offset`.
  - `valid`=1 from cycle 1+`offset`+RD_LATENCY.
- Retune at edge t:
  - New `offset` visible from cycle t+1.
  - `rd` and `valid` are 0 from cycle t+1.
  - `rd` returns at t+1+`offset`.
  - `valid` returns at t+1+`offset`+RD_LATENCY.
- Disable at edge t: `wr`, `rd` and `valid` are all 0 from cycle t+1.
- With `offset`=1: FILL lasts exactly one cycle.

## Test plan
- Reset then `en`=1 with DEFAULT_OFFSET=64, RD_LATENCY=1:
  - `wr` high at cycle 1, `rd` at cycle 65, `valid` at cycle 66.
  - Delayed sample at cycle 66 equals the mic sample from cycle 1.
- Offset clamp: load `offset_req`=0 then enable -> `offset`=1, FILL lasts one cycle, `rd` high at cycle 2.
- Retune in RUN to 10 at edge 200:
  - `rd`/`valid` low at 201.
  - `rd` high at 211, `valid` high at 212.
  - `wr` never drops.
- `offset_load` on the exact FILL-completion cycle -> stays in FILL, `fill_cnt`=0, RUN delayed by the full new offset.
- `en`=0 and `offset_load`=1 (`offset_req`=5) in the same cycle during RUN:
  - Next cycle: IDLE, `offset`=5, all enables and `valid` 0.
  - Re-enable -> `valid` after 5+1+RD_LATENCY cycles.
- Synchronous `rst` pulse mid-RUN -> all outputs return to reset values next cycle, `offset`=DEFAULT_OFFSET, `state`=0.
